// File: rtl/mux_store_data_pkg.sv
// Shared definitions for the store write-data selector: store size
// encodings, the output-stage state type and parameter helper functions.
package mux_store_pkg;

   // Store size encodings driven by the control unit (2'b11 behaves as word)
   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;

   // Occupancy of the one-entry output stage
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   // Width of a byte offset within a DATA_W-bit word
   function automatic int calcOffW(input int dataW);
      return (dataW / 8 > 1) ? $clog2(dataW / 8) : 1;
   endfunction

   // Width of the source selector (never narrower than one bit)
   function automatic int calcSelW(input int numIn);
      return (numIn > 1) ? $clog2(numIn) : 1;
   endfunction

endpackage

// File: rtl/mux_store_data_if.sv
// Request/response bundle between the control/datapath side (master) and
// the write-data selector (slave).
interface mux_store_data_if
   import mux_store_pkg::*;
#(
   parameter int NUM_IN = 7,
   parameter int DATA_W = 32,
   parameter int SEL_W  = calcSelW(NUM_IN),
   parameter int OFF_W  = calcOffW(DATA_W)
);

   logic                     in_valid;
   logic                     in_ready;
   logic [SEL_W-1:0]         seletor;
   logic [NUM_IN*DATA_W-1:0] in_data;
   logic [1:0]               size;
   logic [OFF_W-1:0]         byte_off;
   logic [DATA_W-1:0]        mem_rdata;
   logic                     out_valid;
   logic                     out_ready;
   logic [DATA_W-1:0]        mem_wdata;
   logic                     sel_err;

   modport master (
      output in_valid, seletor, in_data, size, byte_off, mem_rdata, out_ready,
      input  in_ready, out_valid, mem_wdata, sel_err
   );

   modport slave (
      input  in_valid, seletor, in_data, size, byte_off, mem_rdata, out_ready,
      output in_ready, out_valid, mem_wdata, sel_err
   );

endinterface

// File: rtl/mux_store_data_store_merge.sv
// Combinational lane merge for partial stores: a word store passes the
// source through, half/byte stores overwrite one little-endian lane of the
// old memory word.
module store_merge
   import mux_store_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int OFF_W  = calcOffW(DATA_W)
) (
   input  logic [DATA_W-1:0] src_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic [1:0]        size_i,
   input  logic [OFF_W-1:0]  byte_off_i,
   output logic [DATA_W-1:0] merged_o
);

   logic [OFF_W-1:0] halfOff;
   int               byteBase;
   int               halfBase;

   // Halfword stores always land on an even byte lane
   assign halfOff  = byte_off_i & ~(OFF_W'(1));
   assign byteBase = int'(byte_off_i) * 8;
   assign halfBase = int'(halfOff) * 8;

   // Overlay the selected lane of the source onto the old word
   always_comb begin
      merged_o = mem_rdata_i;
      case (size_i)
         SZ_HALF: merged_o[halfBase +: 16] = src_i[15:0];
         SZ_BYTE: merged_o[byteBase +: 8]  = src_i[7:0];
         SZ_WORD: merged_o = src_i;
         default: merged_o = src_i;
      endcase
   end

endmodule

// File: rtl/mux_store_data.sv
// Memory write-data selector: picks one of NUM_IN sources, merges sb/sh
// stores into the read-back word and holds the result in a one-entry
// valid/ready output stage.
// Optional build macro MUX_STORE_SEL_CHECK_EN adds a sticky out-of-range
// selector flag on sel_err; without it sel_err is tied low.
module mux_store_data
   import mux_store_pkg::*;
#(
   parameter int NUM_IN = 7,
   parameter int DATA_W = 32,
   parameter int SEL_W  = calcSelW(NUM_IN),
   parameter int OFF_W  = calcOffW(DATA_W)
) (
   input logic              clk,
   input logic              reset_n,
   mux_store_data_if.slave  bus
);

   state_t            stateQ, stateD;
   logic [DATA_W-1:0] dataQ, dataD;
   logic [DATA_W-1:0] srcWord;
   logic [DATA_W-1:0] mergedWord;
   logic              capture;

   // Out-of-range selectors fall through to an all-zero source
   always_comb begin
      srcWord = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         if (bus.seletor == SEL_W'(k)) begin
            srcWord = bus.in_data[k*DATA_W +: DATA_W];
         end
      end
   end

   store_merge #(
      .DATA_W (DATA_W),
      .OFF_W  (OFF_W)
   ) uMerge (
      .src_i       (srcWord),
      .mem_rdata_i (bus.mem_rdata),
      .size_i      (bus.size),
      .byte_off_i  (bus.byte_off),
      .merged_o    (mergedWord)
   );

   // An empty stage or a draining consumer lets a new word in every cycle
   assign bus.in_ready  = (stateQ == ST_EMPTY) || bus.out_ready;
   assign capture       = bus.in_valid && bus.in_ready;
   assign bus.out_valid = (stateQ == ST_FULL);
   assign bus.mem_wdata = dataQ;

   // Next state: capture wins over drain so back-to-back transfers stay full
   always_comb begin
      stateD = stateQ;
      dataD  = dataQ;
      if (capture) begin
         stateD = ST_FULL;
         dataD  = mergedWord;
      end else if ((stateQ == ST_FULL) && bus.out_ready) begin
         stateD = ST_EMPTY;
      end
   end

   // Output stage registers; reset discards any held entry
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         stateQ <= ST_EMPTY;
         dataQ  <= '0;
      end else begin
         stateQ <= stateD;
         dataQ  <= dataD;
      end
   end

`ifdef MUX_STORE_SEL_CHECK_EN
   logic selErrQ, selErrD;
   logic selOutOfRange;

   assign selOutOfRange = (int'(bus.seletor) >= NUM_IN);

   // Any capture with a bad selector latches the flag until reset
   always_comb begin
      selErrD = selErrQ | (capture & selOutOfRange);
   end

   // Sticky error register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         selErrQ <= 1'b0;
      end else begin
         selErrQ <= selErrD;
      end
   end

   assign bus.sel_err = selErrQ;
`else
   assign bus.sel_err = 1'b0;
`endif

endmodule

// File: doc/mux_store_data.md
Name: mux_store_data

Overview:
- Parametrised successor to the memory write-data selector.
- Selects one of NUM_IN word sources and merges byte/halfword stores (sb/sh) into the old memory word read back for read-modify-write.
- Presents the result through a one-entry registered output stage with a valid/ready handshake.
- Sits between the datapath register sources and the memory write-data port; the control unit drives `seletor`, `size` and `byte_off`.

Parameters:
- NUM_IN, 7: number of data sources (1..16).
- DATA_W, 32: data width; multiple of 16, >= 16.
- SEL_W, $clog2(NUM_IN) (min 1): selector width.
- OFF_W, $clog2(DATA_W/8): byte-offset width.

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset_n  input  1  synchronous reset, active-low.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request this cycle.
- seletor  input  SEL_W  source index.
- in_data  input  NUM_IN*DATA_W  packed sources; source k is bits [k*DATA_W +: DATA_W].
- size  input  2  00 word, 01 half, 10 byte, 11 reserved (treated as word).
- byte_off  input  OFF_W  byte address of the store within the word.
- mem_rdata  input  DATA_W  old memory word, used for merging.
- out_valid  output  1  mem_wdata valid.
- out_ready  input  1  consumer accepts.
- mem_wdata  output  DATA_W  merged write data.
- sel_err  output  1  sticky flag for an out-of-range selector (see Optional Feature).

Behaviour:
- States: EMPTY, FULL. Reset (reset_n=0 at a clk edge) forces EMPTY, out_valid=0, mem_wdata=0, sel_err=0. Reset has priority over any capture in the same cycle, and a held entry is discarded.
- in_ready = (state==EMPTY) || out_ready. This is combinational and allows back-to-back transfers at one per cycle.
- Capture when in_valid && in_ready:
  - mem_wdata <= merge(src, mem_rdata, size, byte_off); out_valid <= 1; state <= FULL.
  - Latency: request cycle to out_valid is exactly 1 cycle.
- FULL && out_ready && !in_valid: state <= EMPTY, out_valid <= 0. mem_wdata keeps its last value.
- FULL && !out_ready: mem_wdata and out_valid are held stable; in_ready=0.
- FULL && out_ready && in_valid: the new capture replaces the old entry in the same edge; out_valid stays 1.
- Source select: src = in_data slice[seletor] when seletor < NUM_IN, otherwise all zeros (matches the previous unused-select=0 rule).
- Merge rules (little-endian lanes):
  - Word: result = src. byte_off is ignored.
  - Half: result = mem_rdata with the 16-bit lane at byte_off (byte_off[0] ignored, forced even) replaced by src[15:0].
  - Byte: result = mem_rdata with byte lane byte_off replaced by src[7:0].
- mem_rdata and all selection inputs are sampled only at the capture edge. Their values in other cycles are don't-care.

Optional Feature:
- Macro: MUX_STORE_SEL_CHECK_EN.
- Defined:
  - sel_err sets to 1 on any capture with seletor >= NUM_IN.
  - It is sticky until reset.
  - The captured data is still zero-sourced.
- Undefined: sel_err is tied to 0 and no check logic exists. Data behaviour is identical in both builds.

Decomposition:
- Package mux_store_pkg holds:
  - size encodings SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10;
  - state typedef {ST_EMPTY, ST_FULL};
  - a function computing OFF_W from DATA_W.
- Sub-module store_merge: purely combinational lane merge (src, mem_rdata, size, byte_off -> merged). It is instantiated once and tested standalone.

Test Plan:
1. Reset: hold reset_n=0 for 2 cycles with in_valid=1 -> out_valid=0, mem_wdata=0, sel_err=0, state EMPTY.
2. Word select: in_data source 3 = 32'hDEADBEEF, seletor=3, size=00, out_ready=1 -> next cycle out_valid=1, mem_wdata=32'hDEADBEEF. Then seletor=7 -> mem_wdata=0; sel_err=1 only with the macro defined.
3. Byte/half merge:
   - mem_rdata=32'h11223344, src=32'h000000AB, size=10, byte_off=2 -> 32'h11AB3344.
   - size=01, byte_off=3, src=32'h0000CAFE -> 32'hCAFE3344.
4. Backpressure: capture 32'hA5A5A5A5, then out_ready=0 for 3 cycles with in_valid=1 and new data -> in_ready=0, mem_wdata held at 32'hA5A5A5A5. On out_ready=1 the new word is captured at the same edge.
5. Throughput: 8 consecutive requests with in_valid=1, out_ready=1 -> 8 outputs on 8 consecutive cycles, in order, no bubbles.
6. Mid-operation reset: FULL with out_ready=0, assert reset_n=0 for one edge -> out_valid=0 and mem_wdata=0 next cycle; the pending entry never appears.
